// File: rtl/pc_fetch_if.sv
// Fetch-unit bus: branch-control redirect, i-cache read port and decode-side outputs.
// The fetch unit is the master; branch control, i-cache and decode form the slave side.
interface pc_fetch_if;
  logic [1:0]  pcmux_sel;
  logic        redirect_valid;
  logic [15:0] br_target;
  logic [15:0] trap_vector;
  logic        stall_in;
  logic        icache_read;
  logic [15:0] icache_addr;
  logic        icache_resp;
  logic [15:0] icache_rdata;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus2;
  logic [15:0] fetch_count;
  logic [15:0] redirect_count;

  modport master (
    input  pcmux_sel, redirect_valid, br_target, trap_vector, stall_in,
           icache_resp, icache_rdata,
    output icache_read, icache_addr, if_valid, if_instr, if_pc, if_pc_plus2,
           fetch_count, redirect_count
  );

  modport slave (
    output pcmux_sel, redirect_valid, br_target, trap_vector, stall_in,
           icache_resp, icache_rdata,
    input  icache_read, icache_addr, if_valid, if_instr, if_pc, if_pc_plus2,
           fetch_count, redirect_count
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC generation and single-entry instruction fetch with redirect/drain handling.
// Optional performance counters are built only when PC_FETCH_PERF_EN is defined.
//
// state | meaning
// FETCH | read request at pc, waiting for the i-cache response
// VALID | holding a fetched instruction until downstream accepts it
// DRAIN | finishing a read made stale by a redirect; then jump to pending target
module pc_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic        clk,
  input logic        reset,
  pc_fetch_if.master bus
);

  typedef enum logic [1:0] {FETCH, VALID, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] pend_q, pend_d;
  logic [15:0] instr_q, if_pc_q, if_pc_plus2_q;
  logic [15:0] pc_plus2;
  logic [15:0] redir_target;
  logic        redir;
  logic        capture;

  assign pc_plus2     = pc_q + 16'd2;
  assign redir        = bus.redirect_valid &&
                        (bus.pcmux_sel == 2'b01 || bus.pcmux_sel == 2'b10);
  assign redir_target = (bus.pcmux_sel == 2'b01) ? {bus.br_target[15:1], 1'b0}
                                                 : {bus.trap_vector[15:1], 1'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      pend_q        <= '0;
      instr_q       <= '0;
      if_pc_q       <= '0;
      if_pc_plus2_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      if (capture) begin
        instr_q       <= bus.icache_rdata;
        if_pc_q       <= pc_q;
        if_pc_plus2_q <= pc_plus2;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    pend_d          = pend_q;
    capture         = 1'b0;
    bus.icache_read = 1'b0;
    bus.icache_addr = pc_q;
    unique case (state_q)
      FETCH: begin
        bus.icache_read = 1'b1;
        if (redir) begin
          if (bus.icache_resp) begin
            pc_d = redir_target;
          end else begin
            pend_d  = redir_target;
            state_d = DRAIN;
          end
        end else if (bus.icache_resp) begin
          capture = 1'b1;
          pc_d    = pc_plus2;
          state_d = VALID;
        end
      end
      VALID: begin
        // a redirect wins over stall: the held instruction is on the wrong path
        if (redir) begin
          pc_d    = redir_target;
          state_d = FETCH;
        end else if (!bus.stall_in) begin
          state_d = FETCH;
        end
      end
      DRAIN: begin
        bus.icache_read = 1'b1;
        if (redir) pend_d = redir_target;
        if (bus.icache_resp) begin
          pc_d    = redir ? redir_target : pend_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  assign bus.if_valid    = (state_q == VALID);
  assign bus.if_instr    = instr_q;
  assign bus.if_pc       = if_pc_q;
  assign bus.if_pc_plus2 = if_pc_plus2_q;

`ifdef PC_FETCH_PERF_EN
  logic [15:0] fetch_cnt_q, redir_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      if (capture) fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if (redir)   redir_cnt_q <= redir_cnt_q + 16'd1;
    end
  end

  assign bus.fetch_count    = fetch_cnt_q;
  assign bus.redirect_count = redir_cnt_q;
`else
  assign bus.fetch_count    = 16'h0000;
  assign bus.redirect_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus a randomized run
// against an instruction-stream model (expected address of each delivered instruction).
module tb_pc_fetch_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  pc_fetch_if bus();

  pc_fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.redirect_valid = 1'b0;
    bus.pcmux_sel      = 2'b00;
    bus.br_target      = 16'h0000;
    bus.trap_vector    = 16'h0000;
    bus.icache_resp    = 1'b0;
    bus.icache_rdata   = 16'h0000;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    bus.stall_in = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic give_resp(input logic [15:0] data);
    bus.icache_resp  = 1'b1;
    bus.icache_rdata = data;
    tick();
    bus.icache_resp  = 1'b0;
  endtask

  task automatic consume();
    bus.stall_in = 1'b0;
    tick();
    bus.stall_in = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_tests++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_if_valid got %h want 0", bus.if_valid); end
    n_tests++; if (bus.if_instr !== 16'h0000 || bus.if_pc !== 16'h0000 || bus.if_pc_plus2 !== 16'h0000) begin
      n_fail++; $display("FAIL reset_if_regs got %h/%h/%h want 0/0/0", bus.if_instr, bus.if_pc, bus.if_pc_plus2); end
    n_tests++; if (bus.fetch_count !== 16'h0000 || bus.redirect_count !== 16'h0000) begin
      n_fail++; $display("FAIL reset_counters got %h/%h want 0/0", bus.fetch_count, bus.redirect_count); end
    tick(); tick();
    reset = 1'b0;
    n_tests++; if (bus.icache_read !== 1'b1 || bus.icache_addr !== 16'h0000) begin
      n_fail++; $display("FAIL reset_first_read got %b@%h want 1@0000", bus.icache_read, bus.icache_addr); end
  endtask

  task automatic test_basic_fetch();
    tick(); tick();
    n_tests++; if (bus.icache_read !== 1'b1 || bus.icache_addr !== 16'h0000 || bus.if_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_wait got rd=%b addr=%h v=%b want 1/0000/0", bus.icache_read, bus.icache_addr, bus.if_valid); end
    give_resp(16'h1234);
    n_tests++; if (bus.if_valid !== 1'b1 || bus.if_instr !== 16'h1234 || bus.if_pc !== 16'h0000 || bus.if_pc_plus2 !== 16'h0002) begin
      n_fail++; $display("FAIL basic_capture got v=%b i=%h pc=%h p2=%h want 1/1234/0000/0002",
                         bus.if_valid, bus.if_instr, bus.if_pc, bus.if_pc_plus2); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (bus.if_valid !== 1'b1 || bus.icache_read !== 1'b0 || bus.if_instr !== 16'h1234 ||
                     bus.if_pc !== 16'h0000 || bus.if_pc_plus2 !== 16'h0002) begin
        n_fail++; $display("FAIL stall_hold cyc%0d got v=%b rd=%b i=%h pc=%h p2=%h", i, bus.if_valid,
                           bus.icache_read, bus.if_instr, bus.if_pc, bus.if_pc_plus2); end
    end
    consume();
    n_tests++; if (bus.if_valid !== 1'b0 || bus.icache_read !== 1'b1 || bus.icache_addr !== 16'h0002) begin
      n_fail++; $display("FAIL stall_release got v=%b rd=%b addr=%h want 0/1/0002", bus.if_valid, bus.icache_read, bus.icache_addr); end
  endtask

  task automatic test_redirect_drain();
    bus.redirect_valid = 1'b1; bus.pcmux_sel = 2'b01; bus.br_target = 16'h0041;
    tick();
    idle_inputs();
    n_tests++; if (bus.icache_read !== 1'b1 || bus.icache_addr !== 16'h0002 || bus.if_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_hold got rd=%b addr=%h v=%b want 1/0002/0", bus.icache_read, bus.icache_addr, bus.if_valid); end
    give_resp(16'hDEAD);
    n_tests++; if (bus.if_valid !== 1'b0 || bus.icache_read !== 1'b1 || bus.icache_addr !== 16'h0040) begin
      n_fail++; $display("FAIL drain_target got v=%b rd=%b addr=%h want 0/1/0040", bus.if_valid, bus.icache_read, bus.icache_addr); end
    give_resp(16'hBEEF);
    n_tests++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 16'h0040 || bus.if_instr !== 16'hBEEF) begin
      n_fail++; $display("FAIL drain_refetch got v=%b pc=%h i=%h want 1/0040/beef", bus.if_valid, bus.if_pc, bus.if_instr); end
    consume();
  endtask

  task automatic test_redirect_same_cycle();
    bus.redirect_valid = 1'b1; bus.pcmux_sel = 2'b10; bus.trap_vector = 16'h0200;
    give_resp(16'hDEAD);
    idle_inputs();
    n_tests++; if (bus.if_valid !== 1'b0 || bus.icache_read !== 1'b1 || bus.icache_addr !== 16'h0200) begin
      n_fail++; $display("FAIL same_cycle got v=%b rd=%b addr=%h want 0/1/0200", bus.if_valid, bus.icache_read, bus.icache_addr); end
    tick();
    n_tests++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL same_cycle_novalid got %b want 0", bus.if_valid); end
  endtask

  task automatic test_wrap();
    bus.redirect_valid = 1'b1; bus.pcmux_sel = 2'b01; bus.br_target = 16'hFFFF;
    tick();
    idle_inputs();
    give_resp(16'h0000);
    n_tests++; if (bus.icache_addr !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_target got %h want fffe", bus.icache_addr); end
    give_resp(16'h4321);
    n_tests++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 16'hFFFE || bus.if_pc_plus2 !== 16'h0000 || bus.if_instr !== 16'h4321) begin
      n_fail++; $display("FAIL wrap_capture got v=%b pc=%h p2=%h i=%h want 1/fffe/0000/4321",
                         bus.if_valid, bus.if_pc, bus.if_pc_plus2, bus.if_instr); end
    consume();
    n_tests++; if (bus.icache_read !== 1'b1 || bus.icache_addr !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_next got rd=%b addr=%h want 1/0000", bus.icache_read, bus.icache_addr); end
    bus.redirect_valid = 1'b1; bus.pcmux_sel = 2'b11; bus.br_target = 16'h1234; bus.trap_vector = 16'h1234;
    give_resp(16'h0ABC);
    idle_inputs();
    n_tests++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 16'h0000 || bus.if_instr !== 16'h0ABC) begin
      n_fail++; $display("FAIL sel11_ignored got v=%b pc=%h i=%h want 1/0000/0abc", bus.if_valid, bus.if_pc, bus.if_instr); end
    consume();
  endtask

  task automatic test_reset_mid_read();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_tests++; if (bus.icache_addr !== 16'h0000 || bus.if_valid !== 1'b0 || bus.if_pc !== 16'h0000 || bus.icache_read !== 1'b1) begin
      n_fail++; $display("FAIL async_reset got addr=%h v=%b pc=%h rd=%b want 0000/0/0000/1",
                         bus.icache_addr, bus.if_valid, bus.if_pc, bus.icache_read); end
    tick();
    reset = 1'b0;
    give_resp(16'h7777);
    n_tests++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 16'h0000 || bus.if_instr !== 16'h7777) begin
      n_fail++; $display("FAIL post_reset_fetch got v=%b pc=%h i=%h want 1/0000/7777", bus.if_valid, bus.if_pc, bus.if_instr); end
  endtask

  task automatic test_perf();
    logic [15:0] exp_f, exp_r;
`ifdef PC_FETCH_PERF_EN
    exp_f = 16'd4; exp_r = 16'd2;
`else
    exp_f = 16'd0; exp_r = 16'd0;
`endif
    apply_reset();
    give_resp(16'h1111); consume();
    give_resp(16'h2222);
    bus.redirect_valid = 1'b1; bus.pcmux_sel = 2'b01; bus.br_target = 16'h0100;
    tick();
    idle_inputs();
    give_resp(16'h3333); consume();
    bus.redirect_valid = 1'b1; bus.pcmux_sel = 2'b10; bus.trap_vector = 16'h0300;
    give_resp(16'hDEAD);
    idle_inputs();
    give_resp(16'h4444);
    n_tests++; if (bus.if_pc !== 16'h0300 || bus.if_instr !== 16'h4444) begin
      n_fail++; $display("FAIL perf_path got pc=%h i=%h want 0300/4444", bus.if_pc, bus.if_instr); end
    n_tests++; if (bus.fetch_count !== exp_f || bus.redirect_count !== exp_r) begin
      n_fail++; $display("FAIL perf_counts got %0d/%0d want %0d/%0d", bus.fetch_count, bus.redirect_count, exp_f, exp_r); end
  endtask

  // Model: the next delivered instruction comes from exp_pc; a redirect anywhere
  // retargets it, a delivery advances it by 2.
  task automatic test_random();
    logic [15:0] exp_pc, tgt_last, held_instr, held_pc;
    logic        eff_last, prev_valid;
    logic [15:0] exp_f, exp_r;
    logic [1:0]  sel;
    apply_reset();
    exp_pc = 16'h0000; eff_last = 1'b0; tgt_last = '0; prev_valid = 1'b0;
    held_instr = '0; held_pc = '0; exp_f = '0; exp_r = '0;
    for (int i = 0; i <= 3000; i++) begin
      tick();
      if (eff_last) exp_pc = tgt_last;
      n_tests++; if (bus.icache_read !== !bus.if_valid) begin
        n_fail++; $display("FAIL rnd_read_vs_valid cyc%0d got rd=%b v=%b", i, bus.icache_read, bus.if_valid); end
      if (bus.if_valid && !prev_valid) begin
        n_tests++; if (bus.if_pc !== exp_pc || bus.if_instr !== mem_word(exp_pc) || bus.if_pc_plus2 !== exp_pc + 16'd2) begin
          n_fail++; $display("FAIL rnd_deliver cyc%0d got pc=%h i=%h p2=%h want %h/%h/%h", i, bus.if_pc,
                             bus.if_instr, bus.if_pc_plus2, exp_pc, mem_word(exp_pc), exp_pc + 16'd2); end
        exp_pc = exp_pc + 16'd2;
        exp_f  = exp_f + 16'd1;
        held_instr = bus.if_instr; held_pc = bus.if_pc;
      end else if (bus.if_valid && prev_valid) begin
        n_tests++; if (bus.if_instr !== held_instr || bus.if_pc !== held_pc) begin
          n_fail++; $display("FAIL rnd_hold cyc%0d got i=%h pc=%h want %h/%h", i, bus.if_instr, bus.if_pc, held_instr, held_pc); end
      end
      prev_valid = bus.if_valid;
      if (i < 3000) begin
        sel = 2'($urandom_range(0, 3));
        bus.pcmux_sel      = sel;
        bus.br_target      = 16'($urandom);
        bus.trap_vector    = 16'($urandom);
        bus.redirect_valid = ($urandom_range(0, 7) == 0);
        bus.stall_in       = $urandom_range(0, 1) == 1;
        bus.icache_resp    = bus.icache_read && ($urandom_range(0, 2) == 0);
        bus.icache_rdata   = bus.icache_resp ? mem_word(bus.icache_addr) : 16'($urandom);
        eff_last = bus.redirect_valid && (sel == 2'b01 || sel == 2'b10);
        tgt_last = (sel == 2'b01) ? (bus.br_target & 16'hFFFE) : (bus.trap_vector & 16'hFFFE);
        if (eff_last) exp_r = exp_r + 16'd1;
      end else begin
        idle_inputs();
        bus.stall_in = 1'b1;
        eff_last = 1'b0;
      end
    end
`ifndef PC_FETCH_PERF_EN
    exp_f = 16'd0; exp_r = 16'd0;
`endif
    n_tests++; if (bus.fetch_count !== exp_f || bus.redirect_count !== exp_r) begin
      n_fail++; $display("FAIL rnd_counts got %0d/%0d want %0d/%0d", bus.fetch_count, bus.redirect_count, exp_f, exp_r); end
  endtask

  initial begin
    idle_inputs();
    bus.stall_in = 1'b1;
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect_drain();
    test_redirect_same_cycle();
    test_wrap();
    test_reset_mid_read();
    test_perf();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
